// File: rtl/matrix_multiplier_mac_array.sv
`default_nettype none
// ============================================================================
// Module      : matrix_multiplier_mac_array
// Description : Output-stationary multi-cycle matrix multiplier.
//               C[A_ROWS x B_COLUMNS] = A[A_ROWS x K] * B[K x B_COLUMNS],
//               where K = A_COLUMNS_B_ROWS. There is one MAC for each C
//               element, and one K term is added per clock. Valid/ready
//               handshakes are used on both the operand side and the
//               result side.
// Ports       : clk_i        clock, rising edge
//               reset_ni     asynchronous active-low reset
//               in_valid_i   A/B operands valid
//               in_ready_o   block can accept operands (IDLE only)
//               a_i          A, row-major, a_i[i*K+k]
//               b_i          B, row-major, b_i[k*B_COLUMNS+j]
//               out_valid_o  c_o holds a complete result (DONE)
//               out_ready_i  consumer takes the result
//               c_o          C, row-major, c_o[i*B_COLUMNS+j]
// Config      : MATMUL_SIGNED_EN defined   -> operands and result are
//                                             two's-complement
//               MATMUL_SIGNED_EN undefined -> everything is unsigned
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_multiplier_mac_array #(
    parameter int DATA_WIDTH       = 8,
    parameter int A_ROWS           = 2,
    parameter int B_COLUMNS        = 2,
    parameter int A_COLUMNS_B_ROWS = 2,
    // Derived value. The sum of K full-scale products cannot overflow this width.
    parameter int C_DATA_WIDTH     = 2*DATA_WIDTH + $clog2(A_COLUMNS_B_ROWS)
) (
    input  logic                                                clk_i,
    input  logic                                                reset_ni,
    input  logic                                                in_valid_i,
    output logic                                                in_ready_o,
    input  logic [A_ROWS*A_COLUMNS_B_ROWS-1:0][DATA_WIDTH-1:0]  a_i,
    input  logic [A_COLUMNS_B_ROWS*B_COLUMNS-1:0][DATA_WIDTH-1:0] b_i,
    output logic                                                out_valid_o,
    input  logic                                                out_ready_i,
    output logic [A_ROWS*B_COLUMNS-1:0][C_DATA_WIDTH-1:0]       c_o
);

    localparam int c_K  = A_COLUMNS_B_ROWS;
    localparam int c_KW = (c_K > 1) ? $clog2(c_K) : 1;
    localparam int c_PW = 2*DATA_WIDTH;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COMPUTE = 2'd1;
    localparam logic [1:0] c_DONE    = 2'd2;

    logic [1:0]                                         r_state;
    logic [1:0]                                         w_next_state;
    logic [c_KW-1:0]                                    r_k;
    logic [A_ROWS*c_K-1:0][DATA_WIDTH-1:0]              r_a;
    logic [c_K*B_COLUMNS-1:0][DATA_WIDTH-1:0]           r_b;
    logic [A_ROWS*B_COLUMNS-1:0][C_DATA_WIDTH-1:0]      r_acc;
    logic [A_ROWS*B_COLUMNS-1:0][C_DATA_WIDTH-1:0]      w_prod;
    logic                                               w_accept;
    logic                                               w_last;

    assign w_accept = in_valid_i && (r_state == c_IDLE);
    assign w_last   = (r_k == c_KW'(c_K - 1));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        in_ready_o   = 1'b0;
        out_valid_o  = 1'b0;
        case (r_state)
            c_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    w_next_state = c_COMPUTE;
                end
            end
            c_COMPUTE: begin
                if (w_last) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-element product of the current K term
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < A_ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < B_COLUMNS; gj++) begin : g_col
            logic [DATA_WIDTH-1:0] w_a_sel;
            logic [DATA_WIDTH-1:0] w_b_sel;
            logic [c_PW-1:0]       w_a_ext;
            logic [c_PW-1:0]       w_b_ext;
            logic [c_PW-1:0]       w_p;

            // Select the operands for the K term at r_k. Selection is done
            // with a compare loop, so r_k is never used as an index whose
            // width could differ from the array bound.
            always_comb begin
                w_a_sel = '0;
                w_b_sel = '0;
                for (int k = 0; k < c_K; k++) begin
                    if (r_k == c_KW'(k)) begin
                        w_a_sel = r_a[gi*c_K + k];
                        w_b_sel = r_b[k*B_COLUMNS + gj];
                    end
                end
            end

`ifdef MATMUL_SIGNED_EN
            assign w_a_ext = {{DATA_WIDTH{w_a_sel[DATA_WIDTH-1]}}, w_a_sel};
            assign w_b_ext = {{DATA_WIDTH{w_b_sel[DATA_WIDTH-1]}}, w_b_sel};
            // The low 2*DATA_WIDTH bits of the sign-extended product are the
            // exact signed product.
            assign w_p = w_a_ext * w_b_ext;
            assign w_prod[gi*B_COLUMNS + gj] = C_DATA_WIDTH'($signed(w_p));
`else
            assign w_a_ext = {{DATA_WIDTH{1'b0}}, w_a_sel};
            assign w_b_ext = {{DATA_WIDTH{1'b0}}, w_b_sel};
            assign w_p = w_a_ext * w_b_ext;
            assign w_prod[gi*B_COLUMNS + gj] = C_DATA_WIDTH'(w_p);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Operand capture, K counter and accumulators
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_k   <= '0;
        end else if (w_accept) begin
            r_a   <= a_i;
            r_b   <= b_i;
            r_acc <= '0;
            r_k   <= '0;
        end else if (r_state == c_COMPUTE) begin
            for (int e = 0; e < A_ROWS*B_COLUMNS; e++) begin
                r_acc[e] <= r_acc[e] + w_prod[e];
            end
            r_k <= w_last ? '0 : r_k + c_KW'(1);
        end
    end

    // The accumulators are updated only in COMPUTE, so they stay unchanged in DONE and IDLE.
    assign c_o = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_matrix_multiplier_mac_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_multiplier_mac_array
// Description : Directed, table-driven bench for matrix_multiplier_mac_array.
//               Instances: default 2x2x2, K=4 2x2, and K=1 3x1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_multiplier_mac_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   total = 0;
    int   bad   = 0;

`ifdef MATMUL_SIGNED_EN
    localparam logic [16:0] c_FF_EXP = 17'd2;          // (-1)*(-1)*2
    localparam logic [16:0] c_X0 = 17'd9;
    localparam logic [16:0] c_X1 = 17'd131062;         // -10
    localparam logic [16:0] c_X2 = 17'd13;
    localparam logic [16:0] c_X3 = 17'd131058;         // -14
`else
    localparam logic [16:0] c_FF_EXP = 17'd130050;     // 255*255*2
    localparam logic [16:0] c_X0 = 17'd1289;
    localparam logic [16:0] c_X1 = 17'd64246;
    localparam logic [16:0] c_X2 = 17'd1293;
    localparam logic [16:0] c_X3 = 17'd64242;
`endif

    // ---------------- default instance (2x2, K=2) ----------------
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [3:0][7:0]  a, b;
    logic [3:0][16:0] c;

    matrix_multiplier_mac_array dut (
        .clk_i(clk), .reset_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .out_valid_o(out_valid), .out_ready_i(out_ready), .c_o(c)
    );

    // ---------------- K=4 instance (2x2) ----------------
    logic             in_valid4, in_ready4, out_valid4, out_ready4;
    logic [7:0][7:0]  a4, b4;
    logic [3:0][17:0] c4;

    matrix_multiplier_mac_array #(.A_COLUMNS_B_ROWS(4)) dut_k4 (
        .clk_i(clk), .reset_ni(rst_n), .in_valid_i(in_valid4), .in_ready_o(in_ready4),
        .a_i(a4), .b_i(b4), .out_valid_o(out_valid4), .out_ready_i(out_ready4), .c_o(c4)
    );

    // ---------------- K=1 instance (3x1) ----------------
    logic             in_valid1, in_ready1, out_valid1, out_ready1;
    logic [2:0][7:0]  a1;
    logic [0:0][7:0]  b1;
    logic [2:0][15:0] c1;

    matrix_multiplier_mac_array #(.A_ROWS(3), .B_COLUMNS(1), .A_COLUMNS_B_ROWS(1)) dut_k1 (
        .clk_i(clk), .reset_ni(rst_n), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .a_i(a1), .b_i(b1), .out_valid_o(out_valid1), .out_ready_i(out_ready1), .c_o(c1)
    );

    typedef struct {
        logic [3:0][7:0]  a;
        logic [3:0][7:0]  b;
        logic [3:0][16:0] c;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present operands at the negedge. Return #1 after the acceptance edge.
    task automatic accept_default(input logic [3:0][7:0] ta, input logic [3:0][7:0] tb);
        @(negedge clk);
        chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
        a = ta; b = tb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("in_ready_drop", {63'd0, in_ready}, 64'd0);
        chk("out_valid_early", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic wait_valid_default(input int exp_lat);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(exp_lat));
    endtask

    task automatic release_default;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_drop", {63'd0, out_valid}, 64'd0);
        chk("in_ready_back", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        int n;

        // A=[1,2,3,4] B=[5,6,7,8]
        vecs[0].a = {8'd4, 8'd3, 8'd2, 8'd1};
        vecs[0].b = {8'd8, 8'd7, 8'd6, 8'd5};
        vecs[0].c = {17'd50, 17'd43, 17'd22, 17'd19};
        // all 255
        vecs[1].a = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[1].b = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[1].c = {c_FF_EXP, c_FF_EXP, c_FF_EXP, c_FF_EXP};
        // zeros
        vecs[2].a = '0;
        vecs[2].b = '0;
        vecs[2].c = '0;
        // A=[-1,2,-3,4] B=[5,-6,7,-8] (interpretation depends on signedness)
        vecs[3].a = {8'h04, 8'hFD, 8'h02, 8'hFF};
        vecs[3].b = {8'hF8, 8'h07, 8'hFA, 8'h05};
        vecs[3].c = {c_X3, c_X2, c_X1, c_X0};
        // A=[10,0,0,20] B=[3,4,5,6]
        vecs[4].a = {8'd20, 8'd0, 8'd0, 8'd10};
        vecs[4].b = {8'd6, 8'd5, 8'd4, 8'd3};
        vecs[4].c = {17'd120, 17'd100, 17'd40, 17'd30};

        in_valid = 0; out_ready = 0; a = '0; b = '0;
        in_valid4 = 0; out_ready4 = 0; a4 = '0; b4 = '0;
        in_valid1 = 0; out_ready1 = 0; a1 = '0; b1 = '0;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_c", {63'd0, (c === '0)}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int v = 0; v < 5; v++) begin
            accept_default(vecs[v].a, vecs[v].b);
            wait_valid_default(2);
            for (int e = 0; e < 4; e++) begin
                chk($sformatf("vec%0d_c%0d", v, e), 64'(c[e]), 64'(vecs[v].c[e]));
            end
            release_default();
            // The result is kept in IDLE.
            chk($sformatf("vec%0d_idle_hold", v), {63'd0, (c === vecs[v].c)}, 64'd1);
        end

        // ---------------- stall in DONE with new operands offered ----------------
        accept_default(vecs[0].a, vecs[0].b);
        wait_valid_default(2);
        @(negedge clk);
        a = vecs[1].a; b = vecs[1].b; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_c_hold", {63'd0, (c === vecs[0].c)}, 64'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_valid", {63'd0, out_valid}, 64'd0);
        chk("stall_release_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk); #1;             // in_valid is still high, so this edge accepts
        in_valid = 1'b0;
        chk("stall_new_accept", {63'd0, in_ready}, 64'd0);
        wait_valid_default(2);
        chk("stall_new_c", {63'd0, (c === vecs[1].c)}, 64'd1);
        release_default();

        // ---------------- K=4: reset while k=1 ----------------
        @(negedge clk);
        a4 = {8{8'd9}}; b4 = {8{8'd9}}; in_valid4 = 1'b1;
        @(posedge clk); #1;             // E0, acceptance
        in_valid4 = 1'b0;
        @(posedge clk); #1;             // E1, one term accumulated
        chk("k4_partial_nonzero", {63'd0, (c4 !== '0)}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("k4_async_out_valid", {63'd0, out_valid4}, 64'd0);
        chk("k4_async_c", {63'd0, (c4 === '0)}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("k4_ready_after_rst", {63'd0, in_ready4}, 64'd1);
        // A rows [1,2,3,4],[5,6,7,8]; B rows [1,2],[3,4],[5,6],[7,8]
        @(negedge clk);
        a4 = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        b4 = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        a4 = '0; b4 = '0;               // Changes after acceptance must have no effect.
        n = 0;
        while (!out_valid4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("k4_latency", 64'(n), 64'd4);
        chk("k4_c0", 64'(c4[0]), 64'd50);
        chk("k4_c1", 64'(c4[1]), 64'd60);
        chk("k4_c2", 64'(c4[2]), 64'd114);
        chk("k4_c3", 64'(c4[3]), 64'd140);
        @(negedge clk);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        chk("k4_release", {63'd0, out_valid4}, 64'd0);

        // ---------------- K=1, 3x1 ----------------
        @(negedge clk);
        a1 = {8'd4, 8'd3, 8'd2}; b1 = 8'd10; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        chk("k1_in_ready_drop", {63'd0, in_ready1}, 64'd0);
        n = 0;
        while (!out_valid1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("k1_latency", 64'(n), 64'd1);
        chk("k1_c0", 64'(c1[0]), 64'd20);
        chk("k1_c1", 64'(c1[1]), 64'd30);
        chk("k1_c2", 64'(c1[2]), 64'd40);
        @(negedge clk);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        chk("k1_release", {63'd0, in_ready1}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
